// File: rtl/vc_fifo_drain_pkg.sv
// Shared types and constants for the VC FIFO drain controller.
// Destination select bit position, source enum and pipeline depth.
package vc_fifo_drain_pkg;

    // Words that can still land in a destination after go is sampled low;
    // destination almost-full thresholds must leave at least this much room.
    localparam int IN_FLIGHT_DEPTH = 3;
    localparam int WCNT_W          = 4;

    typedef enum logic {
        SRC_VC0 = 1'b0,
        SRC_VC1 = 1'b1
    } vc_src_e;

    function automatic int dest_bit(input int data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/vc_fifo_drain_if.sv
// Bundle of VC FIFO read side, destination write side and status for the drain controller.
interface vc_fifo_drain_if #(
    parameter int data_width = 6
) ();

    // Pop/push semantics: rd_enable_VCx is a pop request honoured whenever
    // the matching empty flag is low, with read data valid one cycle later;
    // push_Dx is a single-cycle write strobe the destination must accept,
    // which it guarantees by raising almost_full_Dx early enough.
    logic                  empty_fifo_VC0;
    logic                  empty_fifo_VC1;
    logic [data_width-1:0] data_out_VC0;
    logic [data_width-1:0] data_out_VC1;
    logic                  almost_full_D0;
    logic                  almost_full_D1;
    logic                  rd_enable_VC0;
    logic                  rd_enable_VC1;
    logic                  push_D0;
    logic                  push_D1;
    logic [data_width-1:0] data_out;
    logic                  idle;

    modport master (
        input  empty_fifo_VC0, empty_fifo_VC1,
        input  data_out_VC0, data_out_VC1,
        input  almost_full_D0, almost_full_D1,
        output rd_enable_VC0, rd_enable_VC1,
        output push_D0, push_D1,
        output data_out, idle
    );

    modport slave (
        output empty_fifo_VC0, empty_fifo_VC1,
        output data_out_VC0, data_out_VC1,
        output almost_full_D0, almost_full_D1,
        input  rd_enable_VC0, rd_enable_VC1,
        input  push_D0, push_D1,
        input  data_out, idle
    );

endinterface

// File: rtl/vc_fifo_drain_wrr_grant.sv
// Weighted round-robin grant between VC0 and VC1, favouring VC0.
// Purely combinational: the caller owns the wcnt register.
module vc_wrr_grant
    import vc_fifo_drain_pkg::*;
#(
    parameter int vc0_weight = 3
) (
    input  logic              empty_vc0,
    input  logic              empty_vc1,
    input  logic              go,
    input  logic [WCNT_W-1:0] wcnt,
    output logic              grant_vc0,
    output logic              grant_vc1,
    output logic [WCNT_W-1:0] wcnt_next
);

    localparam logic [WCNT_W-1:0] WEIGHT = WCNT_W'(vc0_weight);

    always_comb begin
        grant_vc0 = 1'b0;
        grant_vc1 = 1'b0;
        wcnt_next = wcnt;

        if (go && !empty_vc0 && !empty_vc1) begin
            if (wcnt < WEIGHT) begin
                grant_vc0 = 1'b1;
            end else begin
                grant_vc1 = 1'b1;
            end
        end else if (go && !empty_vc0) begin
            grant_vc0 = 1'b1;
        end else if (go && !empty_vc1) begin
            grant_vc1 = 1'b1;
        end

        // The weight only counts VC0 grants that actually made VC1 wait.
        if (grant_vc1 || empty_vc1) begin
            wcnt_next = '0;
        end else if (grant_vc0) begin
            wcnt_next = wcnt + 1'b1;
        end
    end

endmodule

// File: rtl/vc_fifo_drain.sv
// Drains the VC0/VC1 FIFO pair into destinations D0/D1 through a
// two-stage pop/route pipeline, routing on the word's top bit.
module vc_fifo_drain
    import vc_fifo_drain_pkg::*;
#(
    parameter int data_width = 6,
    parameter int vc0_weight = 3
) (
    input  logic              clk,
    input  logic              reset,
    vc_fifo_drain_if.master   bus,
    output logic [WCNT_W-1:0] dbg_wcnt
);

    localparam int MSB = dest_bit(data_width);

    logic                  go;
    logic                  grant_vc0;
    logic                  grant_vc1;
    logic [WCNT_W-1:0]     wcnt;
    logic [WCNT_W-1:0]     wcnt_next;
    logic                  v1;
    vc_src_e               src1;
    logic [data_width-1:0] word;

    // Destination is unknown until the word arrives, so both must have room.
    assign go = !bus.almost_full_D0 && !bus.almost_full_D1;

    vc_wrr_grant #(
        .vc0_weight(vc0_weight)
    ) u_grant (
        .empty_vc0(bus.empty_fifo_VC0),
        .empty_vc1(bus.empty_fifo_VC1),
        .go       (go),
        .wcnt     (wcnt),
        .grant_vc0(grant_vc0),
        .grant_vc1(grant_vc1),
        .wcnt_next(wcnt_next)
    );

    assign bus.rd_enable_VC0 = grant_vc0 && reset;
    assign bus.rd_enable_VC1 = grant_vc1 && reset;
    assign dbg_wcnt          = wcnt;

    assign word = (src1 == SRC_VC1) ? bus.data_out_VC1 : bus.data_out_VC0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt        <= '0;
            v1          <= 1'b0;
            src1        <= SRC_VC0;
            bus.push_D0 <= 1'b0;
            bus.push_D1 <= 1'b0;
            bus.data_out <= '0;
            bus.idle    <= 1'b1;
        end else begin
            wcnt        <= wcnt_next;
            v1          <= grant_vc0 || grant_vc1;
            src1        <= grant_vc1 ? SRC_VC1 : SRC_VC0;
            bus.push_D0 <= v1 && !word[MSB];
            bus.push_D1 <= v1 && word[MSB];
            if (v1) begin
                bus.data_out <= word;
            end
            bus.idle <= bus.empty_fifo_VC0 && bus.empty_fifo_VC1 && !v1 &&
                        !(bus.push_D0 || bus.push_D1);
        end
    end

endmodule
